// File: rtl/pipe_chain.sv
// Elastic register chain with valid/ready handshake, flush and freeze.
// Bubbles collapse toward the output; full chain streams one word per cycle.

module pipe_stage #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             adv,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= INIT;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (adv) begin
            valid <= up_valid;
            // Data only moves with a real word so bubbles never clobber it.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

module pipe_chain #(
    parameter int               WIDTH = 32,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             go;
    logic             room;
    logic [OW-1:0]    occ;

    assign go = enable & ~flush;

    // Walk from the output back so each stage sees its successor's advance.
    always_comb begin
        adv  = '0;
        room = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = go & (~v[i] | room);
            room   = adv[i];
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OW'(v[i]);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .adv      (adv[i]),
            .up_valid (up_v),
            .up_data  (up_d),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign in_ready  = adv[0];
    assign out_valid = v[DEPTH-1] & go;
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: DEPTH=3 main instance, DEPTH=1 slice alongside.

module tb_pipe_chain;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       rdy3;
    logic       ov3;
    logic [7:0] od3;
    logic [1:0] oc3;

    logic       rdy1;
    logic       ov1;
    logic [7:0] od1;
    logic [0:0] oc1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_chain #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_ready (out_ready),
        .occupancy (oc3)
    );

    pipe_chain #(.WIDTH(8), .DEPTH(1), .INIT(8'hA5)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy1),
        .out_valid (ov1),
        .out_data  (od1),
        .out_ready (out_ready),
        .occupancy (oc1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ev;
        int acc;
        int em;

        reset     = 1'b1;
        enable    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #1;
        check("rst_ov", 32'(ov3), 0);
        check("rst_od", 32'(od3), 'hA5);
        check("rst_occ", 32'(oc3), 0);
        check("rst_rdy", 32'(rdy3), 1);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("idle_ov", 32'(ov3), 0);
        check("idle_od", 32'(od3), 'hA5);
        check("idle_occ", 32'(oc3), 0);
        check("idle_rdy", 32'(rdy3), 1);
        check("idle_rdy1", 32'(rdy1), 1);

        // Streaming 01..06 with downstream always ready.
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            in_valid = (j < 6);
            in_data  = 8'(j + 1);
            #1;
            ev  = (j >= 3 && j <= 8) ? 1 : 0;
            acc = (j < 6) ? j : 6;
            em  = (j < 3) ? 0 : ((j - 3 > 6) ? 6 : j - 3);
            check("s3_rdy", 32'(rdy3), 1);
            check("s3_ov", 32'(ov3), 32'(ev));
            if (ev == 1) check("s3_od", 32'(od3), 32'(j - 2));
            check("s3_occ", 32'(oc3), 32'(acc - em));
            ev = (j >= 1 && j <= 6) ? 1 : 0;
            check("s1_ov", 32'(ov1), 32'(ev));
            if (ev == 1) check("s1_od", 32'(od1), 32'(j));
            check("s1_occ", 32'(oc1), 32'(ev));
            check("s1_rdy", 32'(rdy1), 1);
            cyc();
        end

        // Backpressure: fill, block 4th, then accept and emit together.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'(8'h10 + k);
            #1;
            check("bp_rdy", 32'(rdy3), 1);
            cyc();
        end
        in_data = 8'h13;
        #1;
        check("full_rdy", 32'(rdy3), 0);
        check("full_occ", 32'(oc3), 3);
        check("full_ov", 32'(ov3), 1);
        check("full_od", 32'(od3), 'h10);
        cyc();
        check("stall_occ", 32'(oc3), 3);
        check("stall_od", 32'(od3), 'h10);
        out_ready = 1'b1;
        #1;
        check("swap_rdy", 32'(rdy3), 1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("swap_occ", 32'(oc3), 3);
        check("swap_od", 32'(od3), 'h11);
        cyc();
        check("drain_od12", 32'(od3), 'h12);
        cyc();
        check("drain_od13", 32'(od3), 'h13);
        check("drain_occ1", 32'(oc3), 1);
        cyc();
        check("drain_occ0", 32'(oc3), 0);
        check("drain_ov0", 32'(ov3), 0);

        // Flush a full chain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'(8'h21 + k);
            cyc();
        end
        check("fl_pre_occ", 32'(oc3), 3);
        flush     = 1'b1;
        in_data   = 8'h24;
        out_ready = 1'b1;
        #1;
        check("fl_rdy", 32'(rdy3), 0);
        check("fl_ov", 32'(ov3), 0);
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("fl_occ", 32'(oc3), 0);
        check("fl_ov_after", 32'(ov3), 0);
        check("fl_od_hold", 32'(od3), 'h21);

        // Freeze with two words held.
        in_valid = 1'b1;
        in_data  = 8'h31;
        cyc();
        in_data = 8'h32;
        cyc();
        check("fz_pre_occ", 32'(oc3), 2);
        enable    = 1'b0;
        in_data   = 8'h33;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fz_rdy", 32'(rdy3), 0);
            check("fz_ov", 32'(ov3), 0);
            cyc();
        end
        check("fz_occ", 32'(oc3), 2);
        enable   = 1'b1;
        in_valid = 1'b0;
        #1;
        check("fz_res_ov", 32'(ov3), 0);
        cyc();
        check("fz_res_ov1", 32'(ov3), 1);
        check("fz_res_od1", 32'(od3), 'h31);
        cyc();
        check("fz_res_od2", 32'(od3), 'h32);
        cyc();
        check("fz_res_occ", 32'(oc3), 0);

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h41;
        cyc();
        in_data = 8'h42;
        cyc();
        in_valid = 1'b0;
        check("ar_pre_occ", 32'(oc3), 2);
        #1;
        reset = 1'b1;
        #1;
        check("ar_occ", 32'(oc3), 0);
        check("ar_od", 32'(od3), 'hA5);
        check("ar_ov", 32'(ov3), 0);
        check("ar_od1", 32'(od1), 'hA5);
        reset = 1'b0;
        #1;
        check("ar_rdy", 32'(rdy3), 1);
        in_valid = 1'b1;
        in_data  = 8'h51;
        cyc();
        in_valid = 1'b0;
        #1;
        check("ar_post_occ", 32'(oc3), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
